// File: rtl/regfile_pkg.sv
// Shared register-file parameters, requester ids and address helpers.
package regfile_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned NUM_REGS = 4;

    typedef enum logic {
        REQ_ALU  = 1'b0,
        REQ_LOAD = 1'b1
    } req_id_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // True when the address maps onto an implemented register.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return addr < ADDR_W'(NUM_REGS);
    endfunction

    // Busy bit for an address; unimplemented addresses read as not busy.
    function automatic logic busy_lookup(input logic [NUM_REGS-1:0] vec,
                                         input logic [ADDR_W-1:0]   addr);
        logic hit;
        hit = 1'b0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (addr == ADDR_W'(r)) hit = vec[r];
        end
        return hit;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; pointer names the requester favoured on contention.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_c
);

    req_id_e ptr_q;
    req_id_e ptr_d;

    // Grant selection and pointer update: pointer moves to the loser after any grant.
    always_comb begin
        gnt_c = 2'b00;
        ptr_d = ptr_q;
        if (req_i[0] && (!req_i[1] || ptr_q == REQ_ALU)) begin
            gnt_c[0] = 1'b1;
        end else if (req_i[1]) begin
            gnt_c[1] = 1'b1;
        end
        if (gnt_c[0]) begin
            ptr_d = REQ_LOAD;
        end else if (gnt_c[1]) begin
            ptr_d = REQ_ALU;
        end
    end

    // Pointer register, ALU favoured out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= REQ_ALU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Writeback port scheduler and busy scoreboard in front of the 4x16 register file.
module regfile_wb_scheduler
    import regfile_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rsv_valid,
    input  logic [ADDR_W-1:0]   rsv_addr,
    output logic                rsv_ready,
    input  logic [ADDR_W-1:0]   chk_addr_a,
    output logic                chk_busy_a,
    input  logic [ADDR_W-1:0]   chk_addr_b,
    output logic                chk_busy_b,
    input  logic                wb0_valid,
    input  logic [ADDR_W-1:0]   wb0_addr,
    input  logic [DATA_W-1:0]   wb0_data,
    output logic                wb0_ready,
    input  logic                wb1_valid,
    input  logic [ADDR_W-1:0]   wb1_addr,
    input  logic [DATA_W-1:0]   wb1_data,
    output logic                wb1_ready,
    output logic                rf_write,
    output logic [ADDR_W-1:0]   rf_wr_addr,
    output logic [DATA_W-1:0]   rf_wr_data,
    output logic [NUM_REGS-1:0] busy_vec
);

    logic [1:0]          gnt;
    wb_req_t             wb0_req;
    wb_req_t             wb1_req;
    wb_req_t             win_req;
    logic                any_grant;

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                rf_write_q;
    logic                rf_write_d;
    logic [ADDR_W-1:0]   rf_wr_addr_q;
    logic [ADDR_W-1:0]   rf_wr_addr_d;
    logic [DATA_W-1:0]   rf_wr_data_q;
    logic [DATA_W-1:0]   rf_wr_data_d;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i ({wb1_valid, wb0_valid}),
        .gnt_c (gnt)
    );

    assign wb0_req   = {wb0_addr, wb0_data};
    assign wb1_req   = {wb1_addr, wb1_data};
    assign win_req   = gnt[1] ? wb1_req : wb0_req;
    assign any_grant = |gnt;

    assign wb0_ready = gnt[0];
    assign wb1_ready = gnt[1];

    // Reservation is refused while the target is still pending, which also rules
    // out a same-register set/clear collision.
    assign rsv_ready  = rsv_valid &
                        (!addr_in_range(rsv_addr) | !busy_lookup(busy_q, rsv_addr));
    assign chk_busy_a = addr_in_range(chk_addr_a) & busy_lookup(busy_q, chk_addr_a);
    assign chk_busy_b = addr_in_range(chk_addr_b) & busy_lookup(busy_q, chk_addr_b);

    assign rf_write   = rf_write_q;
    assign rf_wr_addr = rf_wr_addr_q;
    assign rf_wr_data = rf_wr_data_q;
    assign busy_vec   = busy_q;

    // Next-state: scoreboard clear on the register-file write edge, set on reservation,
    // and capture of the granted request into the write-port registers.
    always_comb begin
        busy_d       = busy_q;
        rf_write_d   = 1'b0;
        rf_wr_addr_d = rf_wr_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (rf_write_q && rf_wr_addr_q == ADDR_W'(r)) busy_d[r] = 1'b0;
            if (rsv_ready && rsv_addr == ADDR_W'(r))      busy_d[r] = 1'b1;
        end
        if (any_grant) begin
            rf_write_d   = addr_in_range(win_req.addr);
            rf_wr_addr_d = win_req.addr;
            rf_wr_data_d = win_req.data;
        end
    end

    // State registers; reset drops any in-flight write and clears the scoreboard.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q       <= '0;
            rf_write_q   <= 1'b0;
            rf_wr_addr_q <= '0;
            rf_wr_data_q <= '0;
        end else begin
            busy_q       <= busy_d;
            rf_write_q   <= rf_write_d;
            rf_wr_addr_q <= rf_wr_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
        end
    end

endmodule
